spi_display_receiver: RTL and testbench

Receiving end of the stopwatch's 3-wire display link (mosi, cs, sck). It behaves as a MAX7219-style display controller: it oversamples the serial lines on the system clock, assembles 16-bit frames and decodes them into a digit/control register file. Uses: bench-side display model for the stopwatch top, and an on-chip loopback monitor.

---
 rtl/spi_display_receiver.sv | 226 ++++++++++++++++++++++
 tb/tb_spi_display_receiver.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_display_receiver.sv
// spi_display_receiver: MAX7219-style display controller fed by a 3-wire serial link.
// Latency: pin edge -> internal event SYNC_STAGES+1 clk; register commit 1 clk after synced cs rise.
// Backpressure: none; the sender must keep sck at or below clk/4 and frames are taken as they arrive.
//
// Ports: clk/rst_n (async active-low); sck/cs/mosi serial link (async to clk);
//   rd_digit/rd_data combinational digit read; decode_mode/intensity/scan_limit/
//   shutdown_n/display_test control registers; frame_valid/frame_error one-cycle
//   pulses; frame_addr/frame_data last committed frame; frame_count committed frames.
module spi_display_receiver #(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_BITS  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sck,
  input  logic        cs,
  input  logic        mosi,
  input  logic [2:0]  rd_digit,
  output logic [7:0]  rd_data,
  output logic [7:0]  decode_mode,
  output logic [3:0]  intensity,
  output logic [2:0]  scan_limit,
  output logic        shutdown_n,
  output logic        display_test,
  output logic        frame_valid,
  output logic [3:0]  frame_addr,
  output logic [7:0]  frame_data,
  output logic        frame_error,
  output logic [15:0] frame_count
);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  localparam logic [4:0] FRAME_LEN = 5'(FRAME_BITS);

  // ---------------------------------------------------------------------------
  // Input synchronizers and edge detection
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sck_dly_q, cs_dly_q;
  // warm_q fills with ones after reset; once full, the cs chain holds real pin
  // samples instead of its reset value, so "cs seen high" can be trusted.
  logic [SYNC_STAGES:0]   warm_q;
  logic                   armed_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync_q  <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sck_dly_q   <= 1'b0;
      cs_dly_q    <= 1'b1;
      warm_q      <= '0;
      armed_q     <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      sck_dly_q   <= sck_sync_q[SYNC_STAGES-1];
      cs_dly_q    <= cs_sync_q[SYNC_STAGES-1];
      warm_q      <= {warm_q[SYNC_STAGES-1:0], 1'b1};
      // A frame may only start after cs has genuinely been observed high,
      // which discards a cs already low when reset is released.
      armed_q     <= armed_q | (warm_q[SYNC_STAGES] & cs_sync_q[SYNC_STAGES-1]);
    end
  end

  logic sck_s, cs_s, mosi_s;
  logic sck_rise, cs_rise, cs_fall;

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_dly_q;
  assign cs_rise  = cs_s & ~cs_dly_q;
  assign cs_fall  = ~cs_s & cs_dly_q & armed_q;

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  state_t state_q, state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cs_fall) state_d = SHIFT;
      SHIFT:   if (cs_rise) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  logic [4:0] cnt_q, cnt_d;
  logic       clr_en, shift_en, commit_en, reject_en;

  always_comb begin
    clr_en    = 1'b0;
    shift_en  = 1'b0;
    commit_en = 1'b0;
    reject_en = 1'b0;
    case (state_q)
      IDLE:   clr_en   = cs_fall;
      // An sck edge landing together with the cs rise does not count.
      SHIFT:  shift_en = sck_rise & ~cs_rise;
      COMMIT: begin
        commit_en = (cnt_q == FRAME_LEN);
        reject_en = (cnt_q != FRAME_LEN);
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath and register file
  // ---------------------------------------------------------------------------
  // Only address/data bits [11:8]/[7:0] are ever used; older frame bits simply
  // fall off the top of a 12-bit shifter.
  logic [11:0] shift_q, shift_d;
  logic [7:0]  digit_q [8];
  logic [7:0]  digit_d [8];
  logic [7:0]  decode_q, decode_d;
  logic [3:0]  intens_q, intens_d;
  logic [2:0]  scan_q, scan_d;
  logic        shdn_n_q, shdn_n_d;
  logic        dtest_q, dtest_d;
  logic        fvld_q, fvld_d;
  logic        ferr_q, ferr_d;
  logic [3:0]  faddr_q, faddr_d;
  logic [7:0]  fdata_q, fdata_d;
  logic [15:0] fcnt_q, fcnt_d;
  logic [3:0]  new_addr;
  logic [7:0]  new_data;

  assign new_addr = shift_q[11:8];
  assign new_data = shift_q[7:0];

  always_comb begin
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    digit_d  = digit_q;
    decode_d = decode_q;
    intens_d = intens_q;
    scan_d   = scan_q;
    shdn_n_d = shdn_n_q;
    dtest_d  = dtest_q;
    faddr_d  = faddr_q;
    fdata_d  = fdata_q;
    fcnt_d   = fcnt_q;
    fvld_d   = commit_en;
    ferr_d   = reject_en;

    if (clr_en) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (shift_en) begin
      shift_d = {shift_q[10:0], mosi_s};
      if (cnt_q != 5'd31) cnt_d = cnt_q + 5'd1;
    end

    if (commit_en) begin
      faddr_d = new_addr;
      fdata_d = new_data;
      fcnt_d  = fcnt_q + 16'd1;
      case (new_addr)
        4'h1, 4'h2, 4'h3, 4'h4,
        4'h5, 4'h6, 4'h7, 4'h8: digit_d[3'(new_addr - 4'd1)] = new_data;
        4'h9:    decode_d = new_data;
        4'hA:    intens_d = new_data[3:0];
        4'hB:    scan_d   = new_data[2:0];
        4'hC:    shdn_n_d = new_data[0];
        4'hF:    dtest_d  = new_data[0];
        default: ;  // 0x0 no-op, 0xD/0xE ignored
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q  <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < 8; i++) digit_q[i] <= '0;
      decode_q <= '0;
      intens_q <= '0;
      scan_q   <= '0;
      shdn_n_q <= 1'b0;
      dtest_q  <= 1'b0;
      fvld_q   <= 1'b0;
      ferr_q   <= 1'b0;
      faddr_q  <= '0;
      fdata_q  <= '0;
      fcnt_q   <= '0;
    end else begin
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      digit_q  <= digit_d;
      decode_q <= decode_d;
      intens_q <= intens_d;
      scan_q   <= scan_d;
      shdn_n_q <= shdn_n_d;
      dtest_q  <= dtest_d;
      fvld_q   <= fvld_d;
      ferr_q   <= ferr_d;
      faddr_q  <= faddr_d;
      fdata_q  <= fdata_d;
      fcnt_q   <= fcnt_d;
    end
  end

  assign rd_data      = digit_q[rd_digit];
  assign decode_mode  = decode_q;
  assign intensity    = intens_q;
  assign scan_limit   = scan_q;
  assign shutdown_n   = shdn_n_q;
  assign display_test = dtest_q;
  assign frame_valid  = fvld_q;
  assign frame_error  = ferr_q;
  assign frame_addr   = faddr_q;
  assign frame_data   = fdata_q;
  assign frame_count  = fcnt_q;

endmodule

// File: tb/tb_spi_display_receiver.sv
// Bench for spi_display_receiver: drives serial frames at sck = clk/8 and
// checks committed/rejected frames against a queue of expected outcomes,
// plus direct register checks after each scenario.
module tb_spi_display_receiver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sck = 1'b0;
  logic        cs = 1'b1;
  logic        mosi = 1'b0;
  logic [2:0]  rd_digit = 3'd0;
  logic [7:0]  rd_data;
  logic [7:0]  decode_mode;
  logic [3:0]  intensity;
  logic [2:0]  scan_limit;
  logic        shutdown_n;
  logic        display_test;
  logic        frame_valid;
  logic [3:0]  frame_addr;
  logic [7:0]  frame_data;
  logic        frame_error;
  logic [15:0] frame_count;

  spi_display_receiver #(.SYNC_STAGES(2), .FRAME_BITS(16)) dut (
    .clk(clk), .rst_n(rst_n), .sck(sck), .cs(cs), .mosi(mosi),
    .rd_digit(rd_digit), .rd_data(rd_data), .decode_mode(decode_mode),
    .intensity(intensity), .scan_limit(scan_limit), .shutdown_n(shutdown_n),
    .display_test(display_test), .frame_valid(frame_valid),
    .frame_addr(frame_addr), .frame_data(frame_data),
    .frame_error(frame_error), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       err;
    logic [3:0] addr;
    logic [7:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_count = 16'd0;

  // Scoreboard monitor: every pulse must match the oldest expected outcome.
  always @(negedge clk) begin
    if (rst_n && (frame_valid || frame_error)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse valid=%0b error=%0b addr=%h data=%h",
                 frame_valid, frame_error, frame_addr, frame_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.err) begin
          if (frame_error !== 1'b1 || frame_valid !== 1'b0) begin
            errors++;
            $display("FAIL frame_reject got valid=%0b error=%0b want valid=0 error=1",
                     frame_valid, frame_error);
          end
        end else if ({frame_valid, frame_error, frame_addr, frame_data} !==
                     {1'b1, 1'b0, e.addr, e.data}) begin
          errors++;
          $display("FAIL frame_commit got valid=%0b error=%0b addr=%h data=%h want addr=%h data=%h",
                   frame_valid, frame_error, frame_addr, frame_data, e.addr, e.data);
        end
      end
    end
  end

  task automatic shift_bits(input logic [16:0] val, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) begin
      mosi = val[i];
      #40 sck = 1'b1;
      #40 sck = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [16:0] val, input int nbits);
    cs = 1'b0;
    #80;
    shift_bits(val, nbits);
    #40 cs = 1'b1;
    #200;
  endtask

  task automatic send_good(input logic [15:0] f);
    exp_t e;
    e.err = 1'b0; e.addr = f[11:8]; e.data = f[7:0];
    exp_q.push_back(e);
    exp_count = exp_count + 16'd1;
    send_frame({1'b0, f}, 16);
  endtask

  task automatic send_bad(input logic [16:0] val, input int nbits);
    exp_t e;
    e.err = 1'b1; e.addr = 4'h0; e.data = 8'h00;
    exp_q.push_back(e);
    send_frame(val, nbits);
  endtask

  task automatic check_digit(input logic [2:0] idx, input logic [7:0] want);
    rd_digit = idx;
    #1;
    checks++;
    if (rd_data !== want) begin
      errors++;
      $display("FAIL digit%0d got %h want %h", idx, rd_data, want);
    end
  endtask

  task automatic check_count(input string tag);
    checks++;
    if (frame_count !== exp_count) begin
      errors++;
      $display("FAIL %s frame_count got %0d want %0d", tag, frame_count, exp_count);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #33 rst_n = 1'b1;
    #100;
    for (int i = 0; i < 8; i++) check_digit(3'(i), 8'h00);
    checks++;
    if ({shutdown_n, intensity, scan_limit, decode_mode, display_test} !== 17'd0) begin
      errors++;
      $display("FAIL reset_regs got sd=%0b int=%h scan=%0d dec=%h test=%0b want all 0",
               shutdown_n, intensity, scan_limit, decode_mode, display_test);
    end
    checks++;
    if (frame_valid !== 1'b0 || frame_error !== 1'b0) begin
      errors++;
      $display("FAIL reset_pulses got valid=%0b error=%0b want 0 0", frame_valid, frame_error);
    end
    check_count("reset");
  endtask

  task automatic test_shutdown();
    send_good(16'h0C01);
    checks++;
    if (shutdown_n !== 1'b1) begin
      errors++;
      $display("FAIL shutdown_n got %0b want 1", shutdown_n);
    end
    check_count("shutdown");
  endtask

  task automatic test_digits();
    send_good(16'h0135);
    send_good(16'h087E);
    check_digit(3'd0, 8'h35);
    check_digit(3'd7, 8'h7E);
    check_digit(3'd3, 8'h00);
    send_good(16'h0A1F);
    checks++;
    if (intensity !== 4'hF) begin
      errors++;
      $display("FAIL intensity got %h want f", intensity);
    end
    send_good(16'h0B0F);
    checks++;
    if (scan_limit !== 3'd7) begin
      errors++;
      $display("FAIL scan_limit got %0d want 7", scan_limit);
    end
    send_good(16'h09A5);
    checks++;
    if (decode_mode !== 8'hA5) begin
      errors++;
      $display("FAIL decode_mode got %h want a5", decode_mode);
    end
    send_good(16'hF433);  // upper nibble ignored, lands in digit3
    check_digit(3'd3, 8'h33);
    check_count("digits");
  endtask

  task automatic test_bad_length();
    send_bad(17'h00166, 15);
    send_bad(17'h10177, 17);
    check_digit(3'd0, 8'h35);
    checks++;
    if (intensity !== 4'hF || scan_limit !== 3'd7) begin
      errors++;
      $display("FAIL bad_len_regs got int=%h scan=%0d want f 7", intensity, scan_limit);
    end
    check_count("bad_length");
  endtask

  task automatic test_cs_high_sck();
    for (int i = 0; i < 20; i++) begin
      mosi = 1'($urandom_range(0, 1));
      #40 sck = 1'b1;
      #40 sck = 1'b0;
    end
    #100;
    send_good(16'h0F01);
    checks++;
    if (display_test !== 1'b1) begin
      errors++;
      $display("FAIL display_test got %0b want 1", display_test);
    end
    send_good(16'h0E55);
    send_good(16'h0066);
    checks++;
    if ({decode_mode, intensity, scan_limit, shutdown_n, display_test} !==
        {8'hA5, 4'hF, 3'd7, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL ignored_addr_regs got dec=%h int=%h scan=%0d sd=%0b test=%0b want a5 f 7 1 1",
               decode_mode, intensity, scan_limit, shutdown_n, display_test);
    end
    for (int i = 0; i < 8; i++)
      if (i != 0 && i != 3 && i != 7) check_digit(3'(i), 8'h00);
    check_count("cs_high_sck");
  endtask

  task automatic test_reset_midframe();
    cs = 1'b0;
    #80;
    shift_bits(17'h00322 >> 9, 7);
    mosi = 1'b0;
    #40 sck = 1'b1;
    #20 rst_n = 1'b0;
    exp_count = 16'd0;
    #20 sck = 1'b0;
    #50 rst_n = 1'b1;  // released with cs still low
    #150 cs = 1'b1;
    #200;
    check_digit(3'd0, 8'h00);
    check_count("after_reset");
    send_good(16'h0344);
    check_digit(3'd2, 8'h44);
    check_count("reset_midframe");
  endtask

  initial begin
    test_reset();
    test_shutdown();
    test_digits();
    test_bad_length();
    test_cs_high_sck();
    test_reset_midframe();
    #200;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_pulses got %0d outstanding want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
